bcd_serial_adder: RTL and testbench



---
 rtl/bcd_serial_adder.sv | 168 ++++++++++++++++
 tb/tb_bcd_serial_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder/subtractor, one digit per clock, LSD first.
// Define BCD_SUB_EN to enable nines'-complement subtraction via the sub input.
module bcd_serial_adder #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_work;
    logic [W-1:0]      r_sum;
    logic [W-1:0]      w_work_next;
    logic [IDXW-1:0]   r_idx;
    logic [IDXW+1:0]   w_base;
    logic              r_carry;
    logic              r_cout;
    logic              r_err;
    logic              w_accept;
    logic              w_last;
    logic              w_err_in;
    logic              w_c0;
    logic [3:0]        w_a_dig;
    logic [3:0]        w_b_dig;
    logic [3:0]        w_b_eff;
    logic [4:0]        w_raw;
    logic [3:0]        w_digit;
    logic              w_cdig;

`ifdef BCD_SUB_EN
    logic              r_sub;
`else
    logic              w_unused_sub;
    assign w_unused_sub = sub;
`endif

    // A start seen while leaving DONE is taken directly, giving DIGITS+1 throughput.
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = start ? RUN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_err_in = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                w_err_in = 1'b1;
            end
        end
    end

`ifdef BCD_SUB_EN
    assign w_c0 = sub ? 1'b1 : cin;
`else
    assign w_c0 = cin;
`endif

    always_comb begin
        w_base  = {r_idx, 2'b00};
        w_a_dig = r_a[w_base +: 4];
        w_b_dig = r_b[w_base +: 4];
`ifdef BCD_SUB_EN
        w_b_eff = r_sub ? (4'd9 - w_b_dig) : w_b_dig;
`else
        w_b_eff = w_b_dig;
`endif
        w_raw   = {1'b0, w_a_dig} + {1'b0, w_b_eff} + {4'b0000, r_carry};
        if (w_raw > 5'd9) begin
            w_digit = w_raw[3:0] + 4'd6;
            w_cdig  = 1'b1;
        end else begin
            w_digit = w_raw[3:0];
            w_cdig  = 1'b0;
        end
        w_work_next = r_work;
        w_work_next[w_base +: 4] = w_digit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
`ifdef BCD_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_work  <= '0;
            r_idx   <= '0;
            r_carry <= w_c0;
            r_err   <= w_err_in;
`ifdef BCD_SUB_EN
            r_sub   <= sub;
`endif
        end else if (r_state == RUN) begin
            r_work  <= w_work_next;
            r_carry <= w_cdig;
            if (w_last) begin
                r_idx  <= '0;
                r_sum  <= w_work_next;
                r_cout <= w_cdig;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (DIGITS=4): stimulus pushes expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_bcd_serial_adder;

    localparam int unsigned DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
            end else begin
                e = q.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic push_exp(input logic [15:0] esum, input logic ecout, input logic eerr);
        exp_t e;
        e.sum  = esum;
        e.cout = ecout;
        e.err  = eerr;
        q.push_back(e);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                          input logic tsub, input logic [15:0] esum, input logic ecout,
                          input logic eerr, input bit poke);
        int busy_cnt;
        int done_cyc;
        push_exp(esum, ecout, eerr);
        @(negedge clk);
        a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_cnt = 0;
        done_cyc = -1;
        for (int cyc = 0; cyc < 20 && done_cyc < 0; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            if (cyc == 0) check("err_early", 32'(err), 32'(eerr));
            if (poke && cyc == 1) begin
                a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
            end
            if (poke && cyc == 2) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) done_cyc = cyc;
        end
        check("latency", 32'(done_cyc), 32'(DIGITS));
        check("busy_cycles", 32'(busy_cnt), 32'(DIGITS));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int cyc;
        int t_done[3];
        int n_late;

        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op(16'h0000, 16'h9999, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
`ifdef BCD_SUB_EN
        run_op(16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b1, 1'b0, 1'b0);
`else
        run_op(16'h5000, 16'h1234, 1'b0, 1'b1, 16'h6234, 1'b0, 1'b0, 1'b0);
`endif
        run_op(16'h1234, 16'h5000, 1'b0, 1'b1, 16'h6234, 1'b0, 1'b0, 1'b0);
        run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b0);
        run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);

        // Start held high: three back-to-back operations.
        repeat (3) push_exp(16'h0010, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h0005; b = 16'h0005; cin = 1'b0; sub = 1'b0; start = 1'b1;
        n_done = 0;
        cyc = 0;
        while (n_done < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                t_done[n_done] = cyc;
                n_done++;
            end
        end
        start = 1'b0;
        check("held_done_count", 32'(n_done), 3);
        if (n_done == 3) begin
            check("held_interval1", 32'(t_done[1] - t_done[0]), 32'(DIGITS + 1));
            check("held_interval2", 32'(t_done[2] - t_done[1]), 32'(DIGITS + 1));
        end

        // Reset in the second RUN cycle of an invalid-digit operation.
        @(negedge clk);
        a = 16'h00A0; b = 16'h0000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("pre_rst_busy", 32'(busy), 1);
        check("pre_rst_err", 32'(err), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_sum", 32'(sum), 0);
        check("mid_rst_cout", 32'(cout), 0);
        check("mid_rst_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_late = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) n_late++;
        end
        check("no_done_after_rst", 32'(n_late), 0);
        run_op(16'h4321, 16'h1234, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
